// File: rtl/store_buffer_pkg.sv
// Shared CPU store definitions: byte-enable constants, store-size encoding,
// drain FSM states and the queued entry layout.
package store_buffer_pkg;

    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } st_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } drain_state_e;

    // Word address only: the byte offset is folded into be.
    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fmt.sv
// Combinational store formatter: lane-replicated data, byte enables and
// misalignment flag. sb has priority over sh; neither set means sw.
module store_fmt
    import store_buffer_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        sb_i,
    input  logic        sh_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic        misalign_o
);

    st_size_e size;

    always_comb begin
        size       = sb_i ? SZ_B : (sh_i ? SZ_H : SZ_W);
        wdata_o    = data_i;
        be_o       = BE_WORD;
        misalign_o = 1'b0;
        case (size)
            SZ_B: begin
                wdata_o = {4{data_i[7:0]}};
                be_o    = BE_BYTE0 << addr_i[1:0];
            end
            SZ_H: begin
                wdata_o    = {2{data_i[15:0]}};
                be_o       = addr_i[1] ? BE_HALF1 : BE_HALF0;
                misalign_o = addr_i[0];
            end
            default: begin
                wdata_o    = data_i;
                be_o       = BE_WORD;
                misalign_o = (addr_i[1:0] != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: formats CPU stores, queues them in order and
// drains them to data memory over a req/ack handshake.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic          st_sb,
    input  logic          st_sh,
    output logic          st_misalign,
    input  logic [31:0]   ld_addr,
    output logic          ld_hit,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    drain_state_e     state_q, state_d;
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             misalign_q;
    sb_entry_t        entry_q [DEPTH];

    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be;
    logic        fmt_misalign;
    logic        accept, enq, pop;
    sb_entry_t   head_entry;

    store_fmt u_fmt (
        .addr_i     (st_addr),
        .data_i     (st_data),
        .sb_i       (st_sb),
        .sh_i       (st_sh),
        .wdata_o    (fmt_wdata),
        .be_o       (fmt_be),
        .misalign_o (fmt_misalign)
    );

    // Ready comes from the registered count only, so a pop never frees a slot
    // in the same cycle.
    assign st_ready = (count_q < CW'(DEPTH));
    assign accept   = st_valid && st_ready;
    assign enq      = accept && !fmt_misalign;
    assign pop      = (state_q == ST_BUSY) && mem_ack;
    assign count_d  = count_q + CW'(enq) - CW'(pop);

    always_comb begin
        valid_d = valid_q;
        if (pop) valid_d[head_q] = 1'b0;
        if (enq) valid_d[tail_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                mem_req = 1'b1;
                if (mem_ack && (count_d == '0)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            misalign_q <= accept && fmt_misalign;
            if (pop) head_q <= head_q + PW'(1);
            if (enq) tail_q <= tail_q + PW'(1);
        end
    end

    // Payload storage needs no reset; valid_q qualifies every read.
    always_ff @(posedge clk) begin
        if (enq) entry_q[tail_q] <= '{waddr: st_addr[31:2], wdata: fmt_wdata, be: fmt_be};
    end

    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entry_q[i].waddr == ld_addr[31:2])) ld_hit = 1'b1;
        end
    end

    assign head_entry  = entry_q[head_q];
    assign mem_addr    = mem_req ? {head_entry.waddr, 2'b00} : 32'h0;
    assign mem_wdata   = mem_req ? head_entry.wdata : 32'h0;
    assign mem_be      = mem_req ? head_entry.be : 4'h0;
    assign st_misalign = misalign_q;
    assign count       = count_q;
    assign empty       = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a short
// random run, with every completed memory write checked against a queue.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_sb = 1'b0;
    logic        st_sh = 1'b0;
    logic        st_misalign;
    logic [31:0] ld_addr = '0;
    logic        ld_hit;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  count;
    logic        empty;

    int checks = 0;
    int errors = 0;
    logic [67:0] exp_q[$];

    store_buffer #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_sb       (st_sb),
        .st_sh       (st_sh),
        .st_misalign (st_misalign),
        .ld_addr     (ld_addr),
        .ld_hit      (ld_hit),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .count       (count),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a write completes at the edge after a cycle with req && ack.
    always @(negedge clk) begin
        if (!rst && mem_req && mem_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {mem_addr, mem_wdata, mem_be}, '0);
            end else begin
                check("mem_write", {mem_addr, mem_wdata, mem_be}, exp_q.pop_front());
            end
        end
    end

    // Reference formatting written from the store semantics.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic sb, input logic sh);
        logic        mis;
        logic [31:0] w;
        logic [3:0]  be;
        int          n;
        if (sb) begin
            mis = 1'b0;
            w   = {d[7:0], d[7:0], d[7:0], d[7:0]};
            be  = 4'b0001 << a[1:0];
        end else if (sh) begin
            mis = a[0];
            w   = {d[15:0], d[15:0]};
            be  = a[1] ? 4'b1100 : 4'b0011;
        end else begin
            mis = (a[1:0] != 2'b00);
            w   = d;
            be  = 4'b1111;
        end
        st_addr  = a;
        st_data  = d;
        st_sb    = sb;
        st_sh    = sh;
        st_valid = 1'b1;
        n = 0;
        while (!st_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check("st_ready_timeout", 0, 1);
        if (!mis) exp_q.push_back({a[31:2], 2'b00, w, be});
        tick();
        st_valid = 1'b0;
        check("st_misalign", st_misalign, mis);
    endtask

    task automatic drain();
        int n;
        mem_ack = 1'b1;
        n = 0;
        while (!empty && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check("drain_timeout", 0, 1);
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mem_req", mem_req, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_ready", st_ready, 1);
        check("rst_misalign", st_misalign, 0);
        check("rst_mem_out", {mem_addr, mem_wdata, mem_be}, 0);

        // sb into empty buffer: request two edges after accept
        do_store(32'h1003, 32'h0000_00A5, 1'b1, 1'b0);
        check("lat_req_lo", mem_req, 0);
        check("lat_count", count, 1);
        tick();
        check("lat_req_hi", mem_req, 1);
        check("sb_out", {mem_addr, mem_wdata, mem_be}, {32'h1000, 32'hA5A5A5A5, 4'b1000});
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sb_done_req", mem_req, 0);
        check("sb_done_count", count, 0);

        // back-to-back sh then sw with ack held
        mem_ack = 1'b1;
        do_store(32'h2002, 32'h1234BEEF, 1'b0, 1'b1);
        do_store(32'h2004, 32'hCAFEF00D, 1'b0, 1'b0);
        check("b2b_first", {mem_req, mem_addr, mem_be}, {1'b1, 32'h2000, 4'b1100});
        tick();
        check("b2b_second", {mem_req, mem_addr, mem_be}, {1'b1, 32'h2004, 4'b1111});
        tick();
        check("b2b_idle", mem_req, 0);

        // misaligned stores are dropped (ack still high catches stray writes)
        do_store(32'h3001, 32'h1111_2222, 1'b0, 1'b1);
        check("mis_h_count", count, 0);
        tick();
        check("mis_pulse_end", st_misalign, 0);
        do_store(32'h3002, 32'h3333_4444, 1'b0, 1'b0);
        check("mis_w_count", count, 0);
        tick();
        check("mis_req", mem_req, 0);
        check("mis_pulse_end2", st_misalign, 0);
        mem_ack = 1'b0;

        // fill, hold a fifth, single pop, then wrap-around drain
        for (int i = 0; i < 4; i++) do_store(32'h5000 + 32'(i * 4), 32'hA000 + 32'(i), 1'b0, 1'b0);
        check("full_count", count, 4);
        check("full_ready", st_ready, 0);
        st_addr = 32'h5010; st_data = 32'hA004; st_sb = 1'b0; st_sh = 1'b0;
        st_valid = 1'b1;
        exp_q.push_back({32'h5010, 32'hA004, 4'b1111});
        tick();
        tick();
        check("full_hold_count", count, 4);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("pop_count", count, 3);
        check("pop_ready", st_ready, 1);
        tick();
        st_valid = 1'b0;
        check("refill_count", count, 4);
        drain();
        check("fill_empty", empty, 1);

        // load-address hit
        do_store(32'h4008, 32'h5555_6666, 1'b0, 1'b0);
        ld_addr = 32'h400A;
        #1 check("ld_hit_same_word", ld_hit, 1);
        ld_addr = 32'h400C;
        #1 check("ld_hit_other_word", ld_hit, 0);
        tick();
        ld_addr = 32'h400A;
        #1 check("ld_hit_presenting", ld_hit, mem_req);
        drain();
        ld_addr = 32'h400A;
        #1 check("ld_hit_drained", ld_hit, 0);

        // reset mid-transfer
        for (int i = 0; i < 3; i++) do_store(32'h6000 + 32'(i * 4), 32'(i), 1'b0, 1'b0);
        check("pre_rst_state", {mem_req, count}, {1'b1, 3'd3});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        check("post_rst_nopop", {mem_req, count}, 0);

        // random mix with random ack
        for (int i = 0; i < 40; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            if (count == 3'd4) mem_ack = 1'b1;
            if ($urandom_range(0, 1) == 1)
                do_store({16'h7000, 8'($urandom_range(0, 255)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))},
                         $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                tick();
        end
        drain();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write store buffer between the CPU MEM stage and the word-addressed data memory.
- Accepts sw/sh/sb requests and formats each into a word-aligned write: byte-lane-replicated data plus byte enables.
- Queues up to DEPTH entries and drains them in order over a req/ack handshake.
- Flags misaligned stores and reports load-address hits so the pipeline can stall loads that overlap a pending store.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- st_valid  in  1  store request from MEM stage
- st_ready  out  1  buffer can accept; equals (count < DEPTH), from registered count only
- st_addr  in  32  byte address of the store
- st_data  in  32  register rt value; the low byte or halfword is used for sb/sh
- st_sb  in  1  byte store; has priority over st_sh
- st_sh  in  1  halfword store
- st_misalign  out  1  registered pulse: the previous-cycle accepted request was misaligned and was dropped
- ld_addr  in  32  byte address of the load in MEM
- ld_hit  out  1  combinational: some valid entry has the same word address (addr[31:2]) as ld_addr
- mem_req  out  1  write request to data memory
- mem_ack  in  1  memory accepted the current write
- mem_addr  out  32  word-aligned address; bits [1:0] are always 0
- mem_wdata  out  32  formatted write data
- mem_be  out  4  byte enables; bit i covers bits [8i+7:8i]
- count  out  CW  number of valid entries
- empty  out  1  count == 0

Behaviour:
- Handshake: a request is accepted when st_valid && st_ready.
- Misalignment check on every accepted request:
  - sh with addr[0]=1 is misaligned.
  - Word store with addr[1:0]!=0 is misaligned.
  - sb is never misaligned.
  - A misaligned request is not enqueued; st_misalign=1 for exactly the next cycle.
- Formatting for an aligned request, with k=addr[1:0]:
  - sb: wdata={4{data[7:0]}}, be=4'b0001<<k.
  - sh: wdata={2{data[15:0]}}, be=addr[1] ? 4'b1100 : 4'b0011.
  - sw: wdata=data, be=4'b1111.
  - The formatted entry is written at the tail; count increments on the next edge.
- Drain FSM, two states:
  - IDLE: mem_req=0. If count>0 at a clock edge, go to BUSY.
  - BUSY: mem_req=1, presenting the head entry; addr/wdata/be are held stable until ack.
  - On mem_ack in BUSY: pop the head. If the post-pop count>0, stay in BUSY and present the next head in the following cycle, with no bubble. Otherwise go to IDLE.
  - mem_ack while in IDLE is ignored.
- Latency: a store accepted into an empty buffer produces mem_req=1 two cycles after the accept edge (enqueue edge, then the IDLE->BUSY edge).
- Simultaneous enqueue and pop: both take effect in the same cycle; count is unchanged.
- When full, st_ready=0 even if a pop occurs in the same cycle; there is no combinational ready path from mem_ack.
- Pointers: head and tail are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Ordering: strictly FIFO. Write merging is out of scope.
- ld_hit:
  - Compares ld_addr[31:2] against every valid entry.
  - Includes the head entry while it is being presented.
  - Does not include a store accepted in the same cycle.
- Reset values: state=IDLE, head=tail=count=0, all valid=0, mem_req=0, st_misalign=0, empty=1, st_ready=1. mem_addr/mem_wdata/mem_be are 0 whenever mem_req=0.
- Reset mid-transfer: all queued stores are discarded and mem_req drops on the next cycle. The memory side must tolerate an abandoned request.

Decomposition:
- Shared CPU package holds:
  - BE_BYTE0..BE_WORD byte-enable constants.
  - Store-size encoding: SZ_B, SZ_H, SZ_W.
  - Drain state enum: ST_IDLE, ST_BUSY.
- One natural sub-module: store_fmt. This is combinational (addr, data, sb, sh) -> (wdata, be, misalign), with the sb>sh>sw priority. It is reusable by the uncached path.
- The FIFO storage and drain FSM stay in store_buffer.

Test Plan:
- sb addr=0x1003 data=0x000000A5 -> next edges give mem_req=1, mem_addr=0x1000, mem_wdata=0xA5A5A5A5, mem_be=4'b1000.
- sh addr=0x2002 data=0x1234BEEF, then sw addr=0x2004 data=0xCAFEF00D, with mem_ack held high -> back-to-back writes:
  - first: 0x2000 / 0xBEEFBEEF / 4'b1100
  - second: 0x2004 / 0xCAFEF00D / 4'b1111
  - no idle cycle between them.
- Misaligned stores, sh addr=0x3001 and sw addr=0x3002 -> st_misalign=1 one cycle each, count stays 0, mem_req never asserts.
- Fill with 4 sw while mem_ack=0 -> count=4, st_ready=0, fifth request held. Assert mem_ack for one cycle -> one pop. The fifth request is accepted only in the cycle after count drops to 3. Order is preserved across the pointer wrap.
- Queue sw addr=0x4008 -> ld_addr=0x400A gives ld_hit=1 and ld_addr=0x400C gives ld_hit=0. After the ack drains the entry, ld_hit=0 for 0x400A.
- With 3 entries queued and mem_req=1, pulse rst -> the next cycle shows mem_req=0, count=0, empty=1. A later mem_ack causes no pop.
